// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Control unit for a multicycle LEGv8-style datapath. A Moore state machine
//   walks each instruction through fetch, decode and the execution steps its
//   class needs. Every strobe is registered and decoded from the state being
//   entered, so the outputs always belong to the state shown on `state`.
//
// Ports
//   CLK          : clock, all updates on the rising edge
//   reset        : synchronous active-low reset
//   opcode[10:0] : instruction bits [31:21] from the instruction register
//   Zero         : ALU zero flag (the datapath gates PCWriteCond with it)
//   IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg, Reg2Loc, ALUSrcA,
//   PCWrite, PCWriteCond      : 1-bit registered strobes
//   ALUSrcB[1:0] : 00 B, 01 PC_INC, 10 SignExt, 11 SignExt<<2
//   ALUOp[1:0]   : 00 add, 01 pass-B, 10 funct
//   PCSource[1:0]: 00 ALU result, 01 ALUOut
//   state[3:0]   : current state encoding
//   illegal      : sticky, set once an undecodable opcode reaches TRAP
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int PC_INC = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        Zero,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_CBZ    = 4'd9,
        S_BR     = 4'd10,
        S_TRAP   = 4'd15
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg2loc;
        logic       alu_src_a;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // The increment constant lives in the datapath; control only selects its
    // mux leg. A zero increment makes that leg identical to "no change".
    localparam logic [1:0] SRCB_INC = (PC_INC != 0) ? 2'b01 : 2'b00;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   illegal_q, illegal_d;
    // Cleared by reset: holds the machine in FETCH with strobes low for the
    // first edge after release, so FETCH strobes appear on that edge.
    logic   run_q, run_d;
    logic   is_stur;

    // Zero only qualifies the PC write inside the datapath.
    logic   unused_zero;
    assign unused_zero = Zero;

    function automatic state_t decode_target(input logic [10:0] op);
        state_t nxt;
        nxt = S_TRAP;
        casez (op)
            OP_LDUR, OP_STUR:                 nxt = S_MEMADR;
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: nxt = S_EXEC_R;
            11'b1?01000100?:                  nxt = S_EXEC_I;
            11'b10110100???:                  nxt = S_CBZ;
            11'b000101?????:                  nxt = S_BR;
            default:                          nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic stur);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_INC;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.reg2loc   = stur;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.reg2loc   = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_CBZ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.reg2loc       = 1'b1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_BR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b01;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign is_stur = (opcode == OP_STUR);

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: state_d = decode_target(opcode);
                S_MEMADR: state_d = is_stur ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
                S_MEMWB, S_MEMWR, S_ALUWB, S_CBZ, S_BR: state_d = S_FETCH;
                // TRAP absorbs; unused encodings 11..14 fall in here too.
                default:  state_d = S_TRAP;
            endcase
        end
        // Outputs are decoded from the state being entered so that, once
        // registered, they line up with state_q.
        ctrl_d    = ctrl_for(state_d, is_stur);
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            run_q     <= run_d;
        end
    end

    assign IRWrite     = ctrl_q.ir_write;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IorD        = ctrl_q.iord;
    assign RegWrite    = ctrl_q.reg_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign Reg2Loc     = ctrl_q.reg2loc;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign state       = state_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. A reference model classifies
//   each opcode into an instruction class, expands it into the state walk
//   that class takes, and gives the strobe set each state must show.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    logic        CLK;
    logic        reset;
    logic [10:0] opcode;
    logic        Zero;
    logic        IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg;
    logic        Reg2Loc, ALUSrcA, PCWrite, PCWriteCond;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;
    int mw_pulses = 0;
    int rw_pulses = 0;
    int cycles    = 0;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDR = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] ADDI = 11'b10010001000;
    localparam logic [10:0] SUBI = 11'b11010001001;
    localparam logic [10:0] CBZ  = 11'b10110100000;
    localparam logic [10:0] BR   = 11'b00010100000;
    localparam logic [10:0] BAD  = 11'b11111111111;

    multicycle_control #(.PC_INC(4)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .Zero(Zero),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc),
        .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction classes: 0 LDUR, 1 STUR, 2 R-type, 3 I-type, 4 CBZ, 5 B, 6 illegal.
    function automatic int kind_of(input logic [10:0] op);
        if (op == LDUR) return 0;
        if (op == STUR) return 1;
        if (op == ADD || op == SUB || op == ANDR || op == ORR) return 2;
        if ((op & 11'b10111111110) == 11'b10010001000) return 3;
        if (op[10:3] == 8'b10110100) return 4;
        if (op[10:5] == 6'b000101) return 5;
        return 6;
    endfunction

    // Strobe vector order: IRWrite MemRead MemWrite IorD RegWrite MemtoReg
    // Reg2Loc ALUSrcA PCWrite PCWriteCond ALUSrcB ALUOp PCSource.
    function automatic logic [15:0] exp_outs(input int st, input logic [10:0] op);
        logic ir, mr, mw, iord, rw, m2r, r2l, asa, pcw, pcwc;
        logic [1:0] sb, aop, psrc;
        {ir, mr, mw, iord, rw, m2r, r2l, asa, pcw, pcwc} = '0;
        sb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (st)
            0:  begin ir = 1; mr = 1; sb = 2'd1; pcw = 1; end
            1:  sb = 2'd3;
            2:  begin asa = 1; sb = 2'd2; r2l = (op == STUR); end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; r2l = 1; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin asa = 1; sb = 2'd2; aop = 2'd2; end
            8:  rw = 1;
            9:  begin asa = 1; aop = 2'd1; r2l = 1; pcwc = 1; psrc = 2'd1; end
            10: begin pcw = 1; psrc = 2'd1; end
            default: ;
        endcase
        return {ir, mr, mw, iord, rw, m2r, r2l, asa, pcw, pcwc, sb, aop, psrc};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg, Reg2Loc,
                ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSource};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cycles++;
        if (MemWrite) mw_pulses++;
        if (RegWrite) rw_pulses++;
    endtask

    // Entered while the DUT shows FETCH; walks the whole instruction, ending
    // one cycle past its last state (FETCH again, or still TRAP).
    task automatic run_instr(input logic [10:0] op, input logic z, input string tag);
        int seq[6];
        int n;
        int k;
        k = kind_of(op);
        seq[0] = 0; seq[1] = 1; n = 2;
        case (k)
            0: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; n = 5; end
            1: begin seq[2] = 2; seq[3] = 5; n = 4; end
            2: begin seq[2] = 6; seq[3] = 8; n = 4; end
            3: begin seq[2] = 7; seq[3] = 8; n = 4; end
            4: begin seq[2] = 9; n = 3; end
            5: begin seq[2] = 10; n = 3; end
            default: begin seq[2] = 15; n = 3; end
        endcase
        opcode = op;
        Zero   = z;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (state !== 4'(seq[i]))
                $display("FAIL %s state[%0d]: got %0d expected %0d", tag, i, state, seq[i]);
            else n_pass++;
            n_checks++;
            if (dut_outs() !== exp_outs(seq[i], op))
                $display("FAIL %s outs in state %0d: got %h expected %h", tag, seq[i],
                         dut_outs(), exp_outs(seq[i], op));
            else n_pass++;
            n_checks++;
            if (illegal !== (seq[i] == 15))
                $display("FAIL %s illegal in state %0d: got %b expected %b", tag, seq[i],
                         illegal, (seq[i] == 15));
            else n_pass++;
            n_checks++;
            if ((MemRead & MemWrite) !== 1'b0 || (PCWrite & PCWriteCond) !== 1'b0)
                $display("FAIL %s exclusion: MemRead=%b MemWrite=%b PCWrite=%b PCWriteCond=%b required no pair both 1",
                         tag, MemRead, MemWrite, PCWrite, PCWriteCond);
            else n_pass++;
            tick();
        end
    endtask

    // One reset edge then release; checks the idle and first FETCH cycles.
    task automatic reset_and_release(input string tag);
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== 4'd0 || illegal !== 1'b0 || dut_outs() !== 16'h0)
            $display("FAIL %s in reset: state=%0d illegal=%b outs=%h expected 0/0/0000",
                     tag, state, illegal, dut_outs());
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd0 || dut_outs() !== exp_outs(0, 11'd0))
            $display("FAIL %s first fetch: state=%0d outs=%h expected 0/%h",
                     tag, state, dut_outs(), exp_outs(0, 11'd0));
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0; opcode = LDUR; Zero = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state);
        else n_pass++;
        n_checks++;
        if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal);
        else n_pass++;
        n_checks++;
        if (dut_outs() !== 16'h0) $display("FAIL reset_strobes: got %h expected 0000", dut_outs());
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd0 || dut_outs() !== exp_outs(0, 11'd0))
            $display("FAIL release_fetch: state=%0d outs=%h expected 0/%h",
                     state, dut_outs(), exp_outs(0, 11'd0));
        else n_pass++;
    endtask

    task automatic test_ldur();
        run_instr(LDUR, 1'b0, "ldur");
    endtask

    task automatic test_stur_add();
        int mw0;
        mw0 = mw_pulses;
        run_instr(STUR, 1'b0, "stur");
        run_instr(ADD, 1'b0, "add");
        n_checks++;
        if (mw_pulses - mw0 !== 1)
            $display("FAIL stur_memwrite_count: got %0d expected 1", mw_pulses - mw0);
        else n_pass++;
    endtask

    task automatic test_cbz_b();
        run_instr(CBZ, 1'b1, "cbz");
        run_instr(BR, 1'b1, "b");
        run_instr(SUBI, 1'b0, "subi");
        run_instr(ORR, 1'b0, "orr");
    endtask

    task automatic test_illegal();
        run_instr(BAD, 1'b0, "illegal");
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (state !== 4'd15 || illegal !== 1'b1 || dut_outs() !== 16'h0)
                $display("FAIL trap_hold[%0d]: state=%0d illegal=%b outs=%h expected 15/1/0000",
                         i, state, illegal, dut_outs());
            else n_pass++;
            opcode = 11'($urandom);
            tick();
        end
        reset_and_release("trap_exit");
    endtask

    task automatic test_mid_reset();
        int rw0;
        opcode = LDUR; Zero = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (state !== 4'd3) $display("FAIL midreset_reach_memrd: got %0d expected 3", state);
        else n_pass++;
        rw0 = rw_pulses;
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== 4'd0) $display("FAIL midreset_state: got %0d expected 0", state);
        else n_pass++;
        reset = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (rw_pulses - rw0 !== 0)
            $display("FAIL midreset_regwrite: got %0d pulses expected 0", rw_pulses - rw0);
        else n_pass++;
        // Bring the machine back to a FETCH boundary.
        reset_and_release("midreset_exit");
    endtask

    task automatic test_random();
        logic [10:0] op;
        int start;
        start = cycles;
        while (cycles - start < 200) begin
            case ($urandom_range(0, 7))
                0: op = LDUR;
                1: op = STUR;
                2: case ($urandom_range(0, 3)) 0: op = ADD; 1: op = SUB; 2: op = ANDR; default: op = ORR; endcase
                3: op = {1'b1, 1'($urandom), 8'b01000100, 1'($urandom)};
                4: op = {8'b10110100, 3'($urandom)};
                5: op = {6'b000101, 5'($urandom)};
                default: op = 11'($urandom);
            endcase
            run_instr(op, 1'($urandom), "random");
            if (kind_of(op) == 6) reset_and_release("random_trap_exit");
        end
    endtask

    initial begin
        reset = 1'b0; opcode = 11'd0; Zero = 1'b0;
        test_reset();
        test_ldur();
        test_stur_add();
        test_cbz_b();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide parameter PC_INC, default 4, giving the byte increment applied to PC on fetch via ALUSrcB=01.
REQ-002 The block SHALL provide port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL provide port reset, input, 1, synchronous active-low reset, sampled only on the CLK rising edge.
REQ-004 The block SHALL provide port opcode, input, 11, instruction bits [31:21] taken from the instruction register.
REQ-005 The block SHALL provide port Zero, input, 1, the ALU zero flag.
REQ-006 The block SHALL provide registered outputs IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg, Reg2Loc, ALUSrcA, PCWrite and PCWriteCond, each 1 bit.
REQ-007 The block SHALL provide registered outputs ALUSrcB (2 bits: 00 B, 01 PC_INC, 10 SignExt, 11 SignExt<<2), ALUOp (2 bits: 00 add, 01 pass-B, 10 funct) and PCSource (2 bits: 00 ALU result, 01 ALUOut).
REQ-008 The block SHALL provide port state, output, 4, the current state encoding, plus port illegal, output, 1, the sticky illegal-opcode flag.

Function
REQ-009 The state machine SHALL use this encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, CBZ=9, BR=10, TRAP=15.
REQ-010 Outputs SHALL be a Moore decode of the state register; a value not listed for a state SHALL be 0.
REQ-011 FETCH SHALL assert MemRead, IRWrite, ALUSrcB=01 and PCWrite with ALUOp=00, ALUSrcA=0 and PCSource=00, then go to DECODE.
REQ-012 DECODE SHALL drive ALUSrcB=11 with ALUSrcA=0 and ALUOp=00, then branch on opcode as follows.
  - LDUR 11111000010 or STUR 11111000000: go to MEMADR.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: go to EXEC_R.
  - ADDI/SUBI 1x01000100x: go to EXEC_I.
  - CBZ 10110100xxx: go to CBZ.
  - B 000101xxxxx: go to BR.
  - Any other opcode: go to TRAP.
REQ-013 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, and SHALL assert Reg2Loc when the opcode is STUR; it then goes to MEMRD for LDUR or MEMWR for STUR.
REQ-014 MEMRD SHALL drive MemRead=1 and IorD=1, then go to MEMWB; MEMWB SHALL drive RegWrite=1 and MemtoReg=1, then go to FETCH.
REQ-015 MEMWR SHALL drive MemWrite=1, IorD=1 and Reg2Loc=1, then go to FETCH.
REQ-016 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10; EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=10; both then go to ALUWB.
REQ-017 ALUWB SHALL drive RegWrite=1 and MemtoReg=0, then go to FETCH.
REQ-018 CBZ SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCWriteCond=1 and PCSource=01, then go to FETCH; the datapath qualifies the PC write with Zero.
REQ-019 BR SHALL drive PCWrite=1 and PCSource=01, then go to FETCH.
REQ-020 Instruction latency SHALL be: LDUR 5 cycles; STUR, R-type and I-type 4 cycles; CBZ and B 3 cycles.
REQ-021 TRAP SHALL be absorbing: all strobes SHALL be 0, state SHALL hold at 15, and illegal SHALL be 1 until reset.
REQ-022 Unused encodings 11–14 SHALL transition to TRAP on the next edge.
REQ-023 MemRead and MemWrite SHALL never be asserted in the same cycle.
REQ-024 PCWrite and PCWriteCond SHALL never be asserted in the same cycle.

Reset
REQ-025 When reset is 0 at a rising edge, state SHALL become FETCH and illegal SHALL become 0, regardless of the current state.
REQ-026 While reset is held 0, all strobe outputs SHALL be 0; FETCH outputs SHALL appear on the first edge after reset returns to 1.
REQ-027 Reset asserted mid-instruction (for example in MEMRD) SHALL abort the instruction without a RegWrite pulse.
REQ-028 Reset SHALL have no effect between clock edges.

Verification
REQ-029 LDUR: after reset release, apply opcode=11111000010 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-030 STUR then ADD: apply opcode 11111000000 followed by 10001011000 -> sequences 0,1,2,5 and 0,1,6,8; MemWrite pulses exactly once in state 5.
REQ-031 CBZ with Zero=1, then B: apply opcode 10110100000 followed by 00010100000 -> sequences 0,1,9 and 0,1,10; PCWriteCond=1 in state 9 and PCWrite=1 in state 10.
REQ-032 Illegal opcode: apply 11111111111 -> 0,1,15 with illegal=1; state stays 15 for 10 cycles; reset=0 for 1 edge -> state=0 and illegal=0.
REQ-033 Mid-instruction reset: assert reset=0 while in state 3 -> state=0 next edge and no RegWrite pulse; over a 200-cycle random-opcode run, assert the mutual exclusions in REQ-023 and REQ-024 every cycle.
